// File: rtl/vga_mem_arbiter.sv
// rtl/vga_mem_arbiter.sv - single-port memory arbiter: display fetch > buffered bus writes > bus read
module vga_mem_arbiter #(
    parameter int C_AXI_ADDR_WIDTH = 15,
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic                            clk_i,
    input  logic                            rstn_i,
    input  logic                            disp_req_i,
    input  logic [C_AXI_ADDR_WIDTH-1:0]     disp_addr_i,
    output logic [C_AXI_DATA_WIDTH-1:0]     disp_rdata_o,
    output logic                            disp_rvalid_o,
    input  logic                            axil_wready_i,
    input  logic [C_AXI_ADDR_WIDTH-1:0]     axil_waddr_i,
    input  logic [C_AXI_DATA_WIDTH-1:0]     axil_wdata_i,
    input  logic [C_AXI_DATA_WIDTH/8-1:0]   axil_wstrb_i,
    input  logic                            axil_rreq_i,
    input  logic [C_AXI_ADDR_WIDTH-1:0]     axil_raddr_i,
    output logic [C_AXI_DATA_WIDTH-1:0]     axil_rdata_o,
    output logic                            axil_rvalid_o,
    output logic                            wr_full_o,
    output logic                            wr_ovf_o,
    output logic                            mem_en_o,
    output logic                            mem_we_o,
    output logic [C_AXI_ADDR_WIDTH-1:0]     mem_addr_o,
    output logic [C_AXI_DATA_WIDTH-1:0]     mem_wdata_o,
    output logic [C_AXI_DATA_WIDTH/8-1:0]   mem_wstrb_o,
    input  logic [C_AXI_DATA_WIDTH-1:0]     mem_rdata_i
);

    localparam int STRB_W = C_AXI_DATA_WIDTH / 8;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = PTR_W + 1;

    typedef enum logic [1:0] {G_NONE, G_DISP, G_WR, G_RD} grant_t;
    typedef enum logic [1:0] {R_IDLE, R_PEND, R_DATA} rd_state_t;

    logic [C_AXI_ADDR_WIDTH-1:0] r_fifo_addr [FIFO_DEPTH];
    logic [C_AXI_DATA_WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
    logic [STRB_W-1:0]           r_fifo_strb [FIFO_DEPTH];
    logic [PTR_W-1:0]            r_wptr;
    logic [PTR_W-1:0]            r_rptr;
    logic [CNT_W-1:0]            r_count;
    logic                        r_full;
    logic                        r_ovf;
    logic                        r_disp_rvalid;
    logic [C_AXI_ADDR_WIDTH-1:0] r_raddr;
    logic [C_AXI_DATA_WIDTH-1:0] r_rdata;
    rd_state_t                   r_rd_state;

    rd_state_t                   w_rd_next;
    grant_t                      w_grant;
    logic                        w_enq;
    logic                        w_deq;
    logic [CNT_W-1:0]            w_count_next;

    // A write is accepted only against the registered full flag, so a same-cycle dequeue never makes room for it.
    assign w_enq        = axil_wready_i && !r_full;
    assign w_deq        = (w_grant == G_WR);
    assign w_count_next = r_count + CNT_W'(w_enq) - CNT_W'(w_deq);

    // Fixed-priority grant; held off during reset so the memory port stays quiet.
    always_comb begin
        w_grant = G_NONE;
        if (!rstn_i) begin
            w_grant = G_NONE;
        end else if (disp_req_i) begin
            w_grant = G_DISP;
        end else if (r_count != '0) begin
            w_grant = G_WR;
        end else if (r_rd_state == R_PEND) begin
            w_grant = G_RD;
        end
    end

    // Memory port is driven straight from the grant.
    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_wstrb_o = '0;
        case (w_grant)
            G_DISP: begin
                mem_en_o   = 1'b1;
                mem_addr_o = disp_addr_i;
            end
            G_WR: begin
                mem_en_o    = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = r_fifo_addr[r_rptr];
                mem_wdata_o = r_fifo_data[r_rptr];
                mem_wstrb_o = r_fifo_strb[r_rptr];
            end
            G_RD: begin
                mem_en_o   = 1'b1;
                mem_addr_o = r_raddr;
            end
            default: begin
                mem_en_o = 1'b0;
            end
        endcase
    end

    // Write buffer payload storage; contents are don't-care until the pointers say otherwise.
    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            r_fifo_addr[r_wptr] <= axil_waddr_i;
            r_fifo_data[r_wptr] <= axil_wdata_i;
            r_fifo_strb[r_wptr] <= axil_wstrb_i;
        end
    end

    // Write buffer pointers, occupancy, full flag and sticky overflow.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_enq) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_deq) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == CNT_W'(FIFO_DEPTH));
            if (axil_wready_i && r_full) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Display read data is valid the cycle after its grant.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_disp_rvalid <= 1'b0;
        end else begin
            r_disp_rvalid <= (w_grant == G_DISP);
        end
    end

    // Read FSM state register.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_rd_state <= R_IDLE;
        end else begin
            r_rd_state <= w_rd_next;
        end
    end

    // Read FSM next state; requests outside R_IDLE are ignored.
    always_comb begin
        w_rd_next = r_rd_state;
        case (r_rd_state)
            R_IDLE:  if (axil_rreq_i) w_rd_next = R_PEND;
            R_PEND:  if (w_grant == G_RD) w_rd_next = R_DATA;
            R_DATA:  w_rd_next = R_IDLE;
            default: w_rd_next = R_IDLE;
        endcase
    end

    // Latch the read address on acceptance and keep the last completed read data.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_raddr <= '0;
            r_rdata <= '0;
        end else begin
            if (r_rd_state == R_IDLE && axil_rreq_i) begin
                r_raddr <= axil_raddr_i;
            end
            if (r_rd_state == R_DATA) begin
                r_rdata <= mem_rdata_i;
            end
        end
    end

    assign disp_rdata_o  = mem_rdata_i;
    assign disp_rvalid_o = r_disp_rvalid;
    assign axil_rvalid_o = rstn_i && (r_rd_state == R_DATA);
    assign axil_rdata_o  = axil_rvalid_o ? mem_rdata_i : r_rdata;
    assign wr_full_o     = r_full;
    assign wr_ovf_o      = r_ovf;

endmodule

// File: doc/vga_mem_arbiter.md
VGA_MEM_ARBITER -- requirements
Module: vga_mem_arbiter

Interface
REQ-001 Parameter C_AXI_ADDR_WIDTH, default 15: bus and memory address width.
REQ-002 Parameter C_AXI_DATA_WIDTH, default 32: bus and memory data width.
REQ-003 Parameter FIFO_DEPTH, default 4 (power of 2, min 2): bus write buffer entries.
REQ-004 The block SHALL use one clock, clk_i, with a synchronous active-low reset, rstn_i.
REQ-005 Ports SHALL be:
- clk_i  in  1  system clock, all logic on rising edge.
- rstn_i  in  1  synchronous active-low reset.
- disp_req_i  in  1  display fetch request; always has top priority.
- disp_addr_i  in  C_AXI_ADDR_WIDTH  display fetch address.
- disp_rdata_o  out  C_AXI_DATA_WIDTH  display read data.
- disp_rvalid_o  out  1  display data valid.
- axil_wready_i  in  1  bus write valid, one-cycle pulse per write.
- axil_waddr_i  in  C_AXI_ADDR_WIDTH  write address.
- axil_wdata_i  in  C_AXI_DATA_WIDTH  write data.
- axil_wstrb_i  in  C_AXI_DATA_WIDTH/8  byte strobes.
- axil_rreq_i  in  1  bus read request pulse.
- axil_raddr_i  in  C_AXI_ADDR_WIDTH  read address.
- axil_rdata_o  out  C_AXI_DATA_WIDTH  read data, held until next read completes.
- axil_rvalid_o  out  1  one-cycle read completion pulse.
- wr_full_o  out  1  write FIFO full.
- wr_ovf_o  out  1  sticky: a write was dropped.
- mem_en_o, mem_we_o  out  1 each  memory port enable / write enable.
- mem_addr_o  out  C_AXI_ADDR_WIDTH;  mem_wdata_o  out  C_AXI_DATA_WIDTH;  mem_wstrb_o  out  C_AXI_DATA_WIDTH/8.
- mem_rdata_i  in  C_AXI_DATA_WIDTH  memory read data, valid 1 cycle after a read enable.

Function
REQ-006 Single-port memory SHALL be shared; exactly one grant per cycle: DISP > WR (FIFO head) > RD (pending read) > NONE.
REQ-007 The memory port SHALL be combinational from the grant: DISP -> en=1, we=0, addr=disp_addr_i; WR -> en=1, we=1, addr/wdata/wstrb from FIFO head; RD -> en=1, we=0, addr=latched read address; NONE -> en=0, we=0, wstrb=0.
REQ-008 disp_rvalid_o SHALL assert exactly 1 cycle after a DISP grant; disp_rdata_o = mem_rdata_i in that cycle.
REQ-009 An axil_wready_i pulse SHALL enqueue {addr, data, strb} when the FIFO is not full at that edge; dequeue in the same cycle frees no slot for it.
REQ-010 A write arriving when full SHALL be dropped and set wr_ovf_o; wr_ovf_o clears only on reset.
REQ-011 Simultaneous enqueue and dequeue (not full) SHALL keep occupancy unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-012 wr_full_o SHALL be registered and equal (occupancy == FIFO_DEPTH).
REQ-013 Read FSM states: R_IDLE, R_PEND, R_DATA.
- R_IDLE: axil_rreq_i -> latch axil_raddr_i, go R_PEND.
- R_PEND: grant RD only when disp_req_i=0 and FIFO empty; on grant -> R_DATA.
- R_DATA: capture mem_rdata_i into axil_rdata_o, pulse axil_rvalid_o, -> R_IDLE.
REQ-014 axil_rreq_i in R_PEND or R_DATA SHALL be ignored.
REQ-015 Reads SHALL observe all writes enqueued before the read request (guaranteed by REQ-013 FIFO-empty rule).
REQ-016 Writes enqueued in the same cycle as a read request SHALL also complete before that read.
REQ-017 Continuous disp_req_i SHALL stall WR and RD indefinitely; there is no starvation guard, and nothing is lost while stalled.

Reset
REQ-018 On rstn_i=0 at a clock edge: FIFO emptied, pointers 0, read FSM to R_IDLE, pending read discarded.
REQ-019 Reset values: axil_rdata_o=0, axil_rvalid_o=0, disp_rvalid_o=0, wr_full_o=0, wr_ovf_o=0, mem_en_o=0, mem_we_o=0.
REQ-020 Reset mid-transfer SHALL abort it; no pulse SHALL be generated for the aborted transfer in the cycle after reset release.

Verification
REQ-021 Idle, write 0x41 strb 0001 to 0x4000 -> next cycle mem_en=1, we=1, addr=0x4000, wdata=0x41, wstrb=0001.
REQ-022 disp_req_i high, 5 writes -> first 4 buffered, wr_full_o=1, 5th dropped, wr_ovf_o=1, zero memory writes; drop disp_req_i -> 4 writes issued in order on 4 consecutive cycles.
REQ-023 Write 0xFF to 0x0000, read 0x0000 the same cycle -> write issues first; axil_rvalid_o pulses 2 cycles later with axil_rdata_o=0xFF.
REQ-024 disp_req_i toggling every cycle, read pending, FIFO empty -> RD granted only in cycles with disp_req_i=0; disp_rvalid_o follows every DISP grant by 1 cycle.
REQ-025 rstn_i=0 in R_PEND with 2 FIFO entries -> no rvalid pulse, no memory write after reset; all outputs at reset values.
